led_scan_ctrl: RTL and testbench

Sequencer for the lab's 3-to-8 LED decoder: generates the 3-bit select index and the enable that drive the decoder, so one LED at a time lights in a programmable pattern. A prescaler sets the dwell time per LED. Four sweep modes are supported: up, down, ping-pong and single-shot. The block sits between the board switches/buttons (already debounced and synchronised) and the decoder's `binary_in`/`en_i` inputs.

---
 rtl/led_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_led_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_scan_ctrl
// Description : Sequencer for a 3-to-8 LED decoder. Produces the select index
//               and decoder enable so that one LED at a time is lit, stepping
//               after a programmable dwell. Four sweep modes: up, down,
//               ping-pong and single-shot up.
// Ports       : clk_i    - system clock (rising edge)
//               rst_i    - asynchronous active-high reset
//               start_i  - starts a sweep from IDLE (level, sampled per cycle)
//               stop_i   - aborts a sweep (level, has priority over start)
//               mode_i   - 00 up, 01 down, 10 ping-pong, 11 single-shot up
//               period_i - dwell length minus 1, in clock cycles
//               idx_o    - LED index to the decoder select input
//               en_o     - decoder enable, high while running
//               busy_o   - high while running
//               done_o   - one-cycle pulse when a single-shot sweep ends
// Revision    : 1.0 - initial release
// ============================================================================
module led_scan_ctrl #(
  parameter int DIV_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] period_i,
  output logic [2:0]       idx_o,
  output logic             en_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_PING = 2'b10;
  localparam logic [1:0] M_ONCE = 2'b11;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_cnt;
  logic             r_dir;
  logic [2:0]       r_idx;
  logic             r_done;

  logic             w_start;
  logic             w_step;
  logic             w_last;
  logic [2:0]       w_idx_step;
  logic             w_dir_step;

  // A start is only honoured from IDLE and never together with stop.
  assign w_start = (r_state == S_IDLE) && start_i && !stop_i;
  // Stop suppresses a coincident step, so the index freezes where it was.
  assign w_step  = (r_state == S_RUN) && !stop_i && (r_cnt == r_period);
  // Final step of a single-shot sweep: leave RUN instead of wrapping.
  assign w_last  = w_step && (r_mode == M_ONCE) && (r_idx == 3'd7);

  // Index/direction after a step event.
  always_comb begin
    w_idx_step = r_idx;
    w_dir_step = r_dir;
    case (r_mode)
      M_UP:   w_idx_step = r_idx + 3'd1;
      M_DOWN: w_idx_step = r_idx - 3'd1;
      M_PING: begin
        // Reverse at the ends without re-showing the end LED.
        if (!r_dir) begin
          if (r_idx == 3'd7) begin
            w_dir_step = 1'b1;
            w_idx_step = 3'd6;
          end else begin
            w_idx_step = r_idx + 3'd1;
          end
        end else begin
          if (r_idx == 3'd0) begin
            w_dir_step = 1'b0;
            w_idx_step = 3'd1;
          end else begin
            w_idx_step = r_idx - 3'd1;
          end
        end
      end
      default: begin
        // Single-shot holds 7 on its final step.
        if (r_idx != 3'd7) begin
          w_idx_step = r_idx + 3'd1;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop_i || w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; every output is a direct copy or decode of a flop.
  always_comb begin
    en_o   = (r_state == S_RUN);
    busy_o = (r_state == S_RUN);
    idx_o  = r_idx;
    done_o = r_done;
  end

  // Datapath: captured configuration, dwell counter, index and direction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode   <= 2'b00;
      r_period <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_idx    <= 3'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_mode   <= mode_i;
        r_period <= period_i;
        r_cnt    <= '0;
        r_idx    <= (mode_i == M_DOWN) ? 3'd7 : 3'd0;
        r_dir    <= (mode_i == M_DOWN);
      end else if (r_state == S_RUN) begin
        if (stop_i) begin
          r_cnt <= '0;
        end else if (w_step) begin
          r_cnt <= '0;
          r_idx <= w_idx_step;
          r_dir <= w_dir_step;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_scan_ctrl
// Description : Self-checking bench for led_scan_ctrl. The driver pushes the
//               expected outputs after every clock edge into a queue; a
//               monitor on the falling edge pops and compares. Expected
//               values come from an arithmetic model: the index is a function
//               of the number of whole dwells elapsed since start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_scan_ctrl;

  localparam int TB_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            stop;
  logic [1:0]      mode;
  logic [TB_W-1:0] period;
  logic [2:0]      idx;
  logic            en;
  logic            busy;
  logic            done;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cyc  = 0;

  typedef struct {
    logic [2:0] idx;
    logic       en;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];

  // Model state
  bit m_run;
  int m_mode;
  int m_per;
  int m_k;
  int m_idx;
  bit m_done;

  led_scan_ctrl #(.DIV_W(TB_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .stop_i  (stop),
    .mode_i  (mode),
    .period_i(period),
    .idx_o   (idx),
    .en_o    (en),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  // Index shown after p whole dwells in a given mode.
  function automatic int pat(input int md, input int p);
    int t;
    case (md)
      0: return p % 8;
      1: return 7 - (p % 8);
      2: begin
        t = p % 14;
        return (t < 8) ? t : 14 - t;
      end
      default: return p;
    endcase
  endfunction

  function automatic void model_reset();
    m_run  = 1'b0;
    m_mode = 0;
    m_per  = 0;
    m_k    = 0;
    m_idx  = 0;
    m_done = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input bit st, input int md, input int pr);
    int p;
    m_done = 1'b0;
    if (!m_run) begin
      if (s && !st) begin
        m_run  = 1'b1;
        m_mode = md;
        m_per  = pr;
        m_k    = 0;
        m_idx  = pat(md, 0);
      end
    end else if (st) begin
      m_run = 1'b0;
    end else begin
      m_k = m_k + 1;
      p   = m_k / (m_per + 1);
      if (m_mode == 3 && p == 8) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_idx  = 7;
      end else begin
        m_idx = pat(m_mode, p);
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.idx  = 3'(m_idx);
    e.en   = m_run;
    e.busy = m_run;
    e.done = m_done;
    q.push_back(e);
  endfunction

  // Monitor: compares the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    n_cyc = n_cyc + 1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp = n_cmp + 1;
      if (idx !== e.idx || en !== e.en || busy !== e.busy || done !== e.done) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs cyc %0d: got idx=%0d en=%b busy=%b done=%b, exp idx=%0d en=%b busy=%b done=%b",
                 n_cyc, idx, en, busy, done, e.idx, e.en, e.busy, e.done);
      end
    end
  end

  // One clock cycle: apply inputs, let the edge happen, record expectation.
  task automatic cyc(input bit s, input bit st, input int md, input int pr);
    start  = s;
    stop   = st;
    mode   = 2'(md);
    period = TB_W'(pr);
    @(posedge clk);
    #1;
    model_step(s, st, md, pr);
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    start = 1'b0;
    stop  = 1'b0;
    #6;
    rst = 1'b1;
    #1;
    n_cmp = n_cmp + 1;
    if (idx !== 3'd0 || en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL async_reset: got idx=%0d en=%b busy=%b done=%b, exp all 0", idx, en, busy, done);
    end
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      push_exp();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    mode   = 2'b00;
    period = '0;
    model_reset();
    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push_exp();
    end
    rst = 1'b0;

    // Up, period 2, with start/mode/period changes mid-run that must be ignored
    cyc(1'b1, 1'b0, 0, 2);
    idle(9);
    cyc(1'b1, 1'b0, 1, 5);
    cyc(1'b1, 1'b0, 2, 0);
    idle(16);
    cyc(1'b0, 1'b1, 0, 0);
    idle(2);

    // Ping-pong, period 0
    cyc(1'b1, 1'b0, 2, 0);
    idle(16);
    cyc(1'b0, 1'b1, 0, 0);
    idle(1);

    // Single-shot, period 1; restart accepted in the done cycle
    cyc(1'b1, 1'b0, 3, 1);
    idle(16);
    cyc(1'b1, 1'b0, 0, 0);
    idle(3);
    cyc(1'b0, 1'b1, 0, 0);
    idle(1);

    // Down, period 3, stop on the step edge while showing 5
    cyc(1'b1, 1'b0, 1, 3);
    idle(11);
    cyc(1'b0, 1'b1, 0, 0);
    idle(2);
    // Start and stop together in IDLE
    cyc(1'b1, 1'b1, 0, 0);
    idle(2);

    // Maximum period: dwell of 2^TB_W cycles
    cyc(1'b1, 1'b0, 0, (1 << TB_W) - 1);
    idle(40);
    cyc(1'b0, 1'b1, 0, 0);

    // Asynchronous reset mid-sweep, then a fresh start
    cyc(1'b1, 1'b0, 0, 1);
    idle(5);
    async_reset();
    cyc(1'b1, 1'b0, 2, 1);
    idle(10);
    cyc(1'b0, 1'b1, 0, 0);

    // Randomised stimulus
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 20) == 0, int'($urandom % 4), int'($urandom_range(0, 3)));
    end
    cyc(1'b0, 1'b1, 0, 0);
    idle(2);

    @(negedge clk);
    #1;
    n_cmp = n_cmp + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL queue_drain: got %0d pending, exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
